// File: rtl/ctx_banked_reg_file.sv
// Context-banked register file: NUM_CTX independent register banks with one active bank,
// plus a switch FSM that can zero the target bank one register per cycle before activating it.
module ctx_banked_reg_file #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int NUM_CTX  = 4,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             WRITE,
    input  logic [AW-1:0]    INADDRESS,
    input  logic [WIDTH-1:0] IN,
    input  logic [AW-1:0]    OUT1ADDRESS,
    input  logic [AW-1:0]    OUT2ADDRESS,
    output logic [WIDTH-1:0] OUT1,
    output logic [WIDTH-1:0] OUT2,
    input  logic             CTX_REQ,
    input  logic [CW-1:0]    CTX_TARGET,
    input  logic             CTX_CLEAR,
    output logic             CTX_BUSY,
    output logic             CTX_ACK,
    output logic             CTX_ERR,
    output logic [CW-1:0]    ACTIVE_CTX
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CLEAR  = 2'd1;
    localparam logic [1:0] ST_SWITCH = 2'd2;

    localparam logic [CW:0]   NUM_CTX_W = (CW+1)'(NUM_CTX);
    localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);

    logic [WIDTH-1:0] bank_reg [NUM_CTX][DEPTH];

    logic [1:0]    state_reg,  state_next;
    logic [AW-1:0] cnt_reg,    cnt_next;
    logic [CW-1:0] tgt_reg,    tgt_next;
    logic [CW-1:0] active_reg, active_next;
    logic          ack_reg,    ack_next;
    logic          err_reg,    err_next;

    logic req_valid;
    logic clear_en;
    logic write_blocked;
    logic write_en;

    assign req_valid     = ({1'b0, CTX_TARGET} < NUM_CTX_W);
    assign clear_en      = (state_reg == ST_CLEAR);
    // Clearing the bank we are executing from: the sweep must leave it all-zero, so writes lose.
    assign write_blocked = clear_en && (tgt_reg == active_reg);
    assign write_en      = WRITE && !write_blocked
                           && !((ZERO_REG != 0) && (INADDRESS == '0));

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        tgt_next    = tgt_reg;
        active_next = active_reg;
        ack_next    = 1'b0;
        err_next    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (CTX_REQ) begin
                    if (!req_valid) begin
                        err_next = 1'b1;
                    end else begin
                        tgt_next   = CTX_TARGET;
                        cnt_next   = '0;
                        state_next = CTX_CLEAR ? ST_CLEAR : ST_SWITCH;
                    end
                end
            end
            ST_CLEAR: begin
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == LAST_IDX) begin
                    state_next = ST_SWITCH;
                end
            end
            ST_SWITCH: begin
                active_next = tgt_reg;
                ack_next    = 1'b1;
                state_next  = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            tgt_reg    <= '0;
            active_reg <= '0;
            ack_reg    <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            tgt_reg    <= tgt_next;
            active_reg <= active_next;
            ack_reg    <= ack_next;
            err_reg    <= err_next;
        end
    end

    // Sweep and pipeline write never hit the same entry: same bank implies write_blocked.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int c = 0; c < NUM_CTX; c++) begin
                for (int r = 0; r < DEPTH; r++) begin
                    bank_reg[c][r] <= '0;
                end
            end
        end else begin
            if (clear_en) begin
                bank_reg[tgt_reg][cnt_reg] <= '0;
            end
            if (write_en) begin
                bank_reg[active_reg][INADDRESS] <= IN;
            end
        end
    end

    logic [2*AW-1:0]    rd_addr_all;
    logic [2*WIDTH-1:0] rd_data_all;

    assign rd_addr_all = {OUT2ADDRESS, OUT1ADDRESS};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic [AW-1:0]    port_addr;
            logic [WIDTH-1:0] port_data;

            assign port_addr = rd_addr_all[gi*AW +: AW];

            always_comb begin
                if ((ZERO_REG != 0) && (port_addr == '0)) begin
                    port_data = '0;
                end else if ((BYPASS != 0) && write_en && (INADDRESS == port_addr)) begin
                    port_data = IN;
                end else begin
                    port_data = bank_reg[active_reg][port_addr];
                end
            end

            assign rd_data_all[gi*WIDTH +: WIDTH] = port_data;
        end
    endgenerate

    assign OUT1       = rd_data_all[WIDTH-1:0];
    assign OUT2       = rd_data_all[2*WIDTH-1:WIDTH];
    assign CTX_BUSY   = (state_reg != ST_IDLE);
    assign CTX_ACK    = ack_reg;
    assign CTX_ERR    = err_reg;
    assign ACTIVE_CTX = active_reg;

endmodule

// File: tb/tb_ctx_banked_reg_file.sv
// Directed bench for ctx_banked_reg_file: vector table for read/write/bypass behaviour,
// hand sequences for context switches, clear sweeps, rejected targets and reset mid-clear.
`timescale 1ns/1ps
module tb_ctx_banked_reg_file;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        WRITE;
    logic [4:0]  INADDRESS;
    logic [31:0] IN;
    logic [4:0]  OUT1ADDRESS;
    logic [4:0]  OUT2ADDRESS;
    logic [31:0] OUT1;
    logic [31:0] OUT2;
    logic        CTX_REQ;
    logic [1:0]  CTX_TARGET;
    logic        CTX_CLEAR;
    logic        CTX_BUSY;
    logic        CTX_ACK;
    logic        CTX_ERR;
    logic [1:0]  ACTIVE_CTX;

    logic        req3;
    logic [1:0]  tgt3;
    logic [31:0] out1_3;
    logic [31:0] out2_3;
    logic        busy3;
    logic        ack3;
    logic        err3;
    logic [1:0]  active3;

    int compared   = 0;
    int mismatched = 0;

    always #5 CLK = ~CLK;

    ctx_banked_reg_file u_dut (
        .CLK(CLK), .RESET(RESET), .WRITE(WRITE), .INADDRESS(INADDRESS), .IN(IN),
        .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS), .OUT1(OUT1), .OUT2(OUT2),
        .CTX_REQ(CTX_REQ), .CTX_TARGET(CTX_TARGET), .CTX_CLEAR(CTX_CLEAR),
        .CTX_BUSY(CTX_BUSY), .CTX_ACK(CTX_ACK), .CTX_ERR(CTX_ERR), .ACTIVE_CTX(ACTIVE_CTX)
    );

    // Three contexts make target 3 encodable but out of range.
    ctx_banked_reg_file #(.NUM_CTX(3)) u_dut3 (
        .CLK(CLK), .RESET(RESET), .WRITE(WRITE), .INADDRESS(INADDRESS), .IN(IN),
        .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS), .OUT1(out1_3), .OUT2(out2_3),
        .CTX_REQ(req3), .CTX_TARGET(tgt3), .CTX_CLEAR(CTX_CLEAR),
        .CTX_BUSY(busy3), .CTX_ACK(ack3), .CTX_ERR(err3), .ACTIVE_CTX(active3)
    );

    typedef struct {
        logic        wr;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    vec_t vecs [7];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic wr(input logic [4:0] addr, input logic [31:0] data);
        WRITE = 1'b1; INADDRESS = addr; IN = data;
        tick();
        WRITE = 1'b0;
    endtask

    task automatic rd(input string name, input logic [4:0] addr, input logic [31:0] exp);
        OUT1ADDRESS = addr;
        #1;
        check(name, OUT1, exp);
    endtask

    task automatic do_switch(input logic [1:0] t, input logic clr, input int exp_lat,
                             input logic mid_req, input string name);
        int n;
        int busy_n;
        CTX_REQ = 1'b1; CTX_TARGET = t; CTX_CLEAR = clr;
        tick();
        CTX_REQ = 1'b0; CTX_CLEAR = 1'b0;
        n = 0;
        busy_n = 0;
        while (!CTX_ACK && n < 200) begin
            if (CTX_BUSY) busy_n++;
            if (mid_req && n == 10) begin
                CTX_REQ = 1'b1; CTX_TARGET = 2'd3;
            end else begin
                CTX_REQ = 1'b0;
            end
            tick();
            n++;
        end
        CTX_REQ = 1'b0;
        $display("switch %s: target=%0d clear=%0d ack after %0d edges, busy %0d cycles",
                 name, t, clr, n, busy_n);
        check({name, "_ack_latency"}, 32'(n), 32'(exp_lat));
        check({name, "_busy_cycles"}, 32'(busy_n), 32'(exp_lat));
        check({name, "_active"}, 32'(ACTIVE_CTX), 32'(t));
        check({name, "_busy_at_ack"}, 32'(CTX_BUSY), 32'd0);
        check({name, "_err_at_ack"}, 32'(CTX_ERR), 32'd0);
        tick();
        check({name, "_ack_pulse"}, 32'(CTX_ACK), 32'd0);
        check({name, "_not_queued"}, 32'(CTX_BUSY), 32'd0);
        check({name, "_active_hold"}, 32'(ACTIVE_CTX), 32'(t));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int acks;

        vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0};
        vecs[1] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF};
        vecs[3] = '{1'b1, 5'd7,  32'hA5A5A5A5, 5'd0,  5'd7,  32'h0,        32'hA5A5A5A5};
        vecs[4] = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd0,  32'hA5A5A5A5, 32'h0};
        vecs[5] = '{1'b1, 5'd31, 32'h00000001, 5'd31, 5'd30, 32'h00000001, 32'h0};
        vecs[6] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd7,  32'h00000001, 32'hA5A5A5A5};

        // Reset with a write and a request asserted: both must be ignored.
        RESET = 1'b1; WRITE = 1'b1; INADDRESS = 5'd3; IN = 32'hFFFFFFFF;
        OUT1ADDRESS = 5'd0; OUT2ADDRESS = 5'd0;
        CTX_REQ = 1'b1; CTX_TARGET = 2'd2; CTX_CLEAR = 1'b0;
        req3 = 1'b0; tgt3 = 2'd0;
        tick();
        tick();
        RESET = 1'b0; WRITE = 1'b0; CTX_REQ = 1'b0;
        #1;
        check("reset_busy", 32'(CTX_BUSY), 32'd0);
        check("reset_ack", 32'(CTX_ACK), 32'd0);
        check("reset_err", 32'(CTX_ERR), 32'd0);
        check("reset_active", 32'(ACTIVE_CTX), 32'd0);
        for (int a = 0; a < 32; a++) begin
            OUT1ADDRESS = 5'(a);
            OUT2ADDRESS = 5'(31 - a);
            #1;
            check("reset_out1", OUT1, 32'h0);
            check("reset_out2", OUT2, 32'h0);
        end

        // Read/write/bypass/zero-register vectors in ctx0.
        for (int i = 0; i < 7; i++) begin
            WRITE = vecs[i].wr; INADDRESS = vecs[i].waddr; IN = vecs[i].wdata;
            OUT1ADDRESS = vecs[i].a1; OUT2ADDRESS = vecs[i].a2;
            #1;
            $display("vec %0d: wr=%0d x%0d=0x%08h out1[x%0d]=0x%08h out2[x%0d]=0x%08h",
                     i, vecs[i].wr, vecs[i].waddr, vecs[i].wdata, vecs[i].a1, OUT1, vecs[i].a2, OUT2);
            check($sformatf("vec%0d_out1", i), OUT1, vecs[i].e1);
            check($sformatf("vec%0d_out2", i), OUT2, vecs[i].e2);
            tick();
        end
        WRITE = 1'b0;

        // Bank isolation across a plain switch.
        do_switch(2'd2, 1'b0, 1, 1'b0, "to_ctx2");
        rd("ctx2_x5_empty", 5'd5, 32'h0);
        wr(5'd5, 32'h12345678);
        wr(5'd31, 32'h0BADF00D);
        rd("ctx2_x5", 5'd5, 32'h12345678);
        do_switch(2'd0, 1'b0, 1, 1'b0, "to_ctx0");
        rd("ctx0_x5", 5'd5, 32'hDEADBEEF);
        rd("ctx0_x7", 5'd7, 32'hA5A5A5A5);

        // Fill ctx1, leave it, then clear-switch back with a stray request mid-sweep.
        do_switch(2'd1, 1'b0, 1, 1'b0, "to_ctx1");
        for (int r = 1; r < 32; r++) wr(5'(r), 32'hC0000000 | 32'(r));
        rd("ctx1_x3_filled", 5'd3, 32'hC0000003);
        do_switch(2'd0, 1'b0, 1, 1'b0, "back_ctx0");
        do_switch(2'd1, 1'b1, 33, 1'b1, "clear_ctx1");
        for (int r = 0; r < 32; r++) rd($sformatf("ctx1_cleared_x%0d", r), 5'(r), 32'h0);

        // Clearing the active bank: a write issued mid-sweep must not survive.
        wr(5'd4, 32'h00000044);
        rd("ctx1_x4_written", 5'd4, 32'h00000044);
        CTX_REQ = 1'b1; CTX_TARGET = 2'd1; CTX_CLEAR = 1'b1;
        tick();
        CTX_REQ = 1'b0; CTX_CLEAR = 1'b0;
        repeat (20) tick();
        wr(5'd2, 32'h00000077);
        n = 0;
        while (!CTX_ACK && n < 200) begin
            tick();
            n++;
        end
        check("self_clear_ack_remaining", 32'(n), 32'd12);
        rd("self_clear_x2_dropped", 5'd2, 32'h0);
        rd("self_clear_x4", 5'd4, 32'h0);

        // Out-of-range target on the three-context instance.
        req3 = 1'b1; tgt3 = 2'd3;
        tick();
        req3 = 1'b0;
        $display("dut3 request target 3: err=%0d ack=%0d active=%0d", err3, ack3, active3);
        check("err_pulse", 32'(err3), 32'd1);
        check("err_no_ack", 32'(ack3), 32'd0);
        check("err_no_busy", 32'(busy3), 32'd0);
        check("err_active", 32'(active3), 32'd0);
        tick();
        check("err_pulse_end", 32'(err3), 32'd0);
        check("err_still_no_ack", 32'(ack3), 32'd0);
        req3 = 1'b1; tgt3 = 2'd2;
        tick();
        req3 = 1'b0;
        check("dut3_valid_busy", 32'(busy3), 32'd1);
        check("dut3_valid_err", 32'(err3), 32'd0);
        tick();
        check("dut3_valid_ack", 32'(ack3), 32'd1);
        check("dut3_valid_active", 32'(active3), 32'd2);

        // Reset ten cycles into a clear of ctx2.
        do_switch(2'd0, 1'b0, 1, 1'b0, "pre_reset_ctx0");
        CTX_REQ = 1'b1; CTX_TARGET = 2'd2; CTX_CLEAR = 1'b1;
        tick();
        CTX_REQ = 1'b0; CTX_CLEAR = 1'b0;
        repeat (9) tick();
        check("midclear_busy", 32'(CTX_BUSY), 32'd1);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        $display("reset mid-clear: busy=%0d ack=%0d active=%0d", CTX_BUSY, CTX_ACK, ACTIVE_CTX);
        check("midreset_busy", 32'(CTX_BUSY), 32'd0);
        check("midreset_ack", 32'(CTX_ACK), 32'd0);
        check("midreset_active", 32'(ACTIVE_CTX), 32'd0);
        acks = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (CTX_ACK) acks++;
        end
        check("midreset_no_ack", 32'(acks), 32'd0);
        for (int r = 0; r < 32; r++) rd($sformatf("midreset_ctx0_x%0d", r), 5'(r), 32'h0);
        do_switch(2'd2, 1'b0, 1, 1'b0, "post_reset_ctx2");
        rd("midreset_ctx2_x5", 5'd5, 32'h0);
        rd("midreset_ctx2_x31", 5'd31, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ctx_banked_reg_file.md
Name: ctx_banked_reg_file

Overview:
- Parametrised successor to the processor's single 32x32 register file. Holds NUM_CTX independent register banks, one per software context.
- Reads and writes always target the active bank. An OS-initiated switch request selects a new active bank, optionally zero-clearing it first by a one-register-per-cycle sweep.
- Sits in the ID/WB stages of the RISC-V core. Pairs with the context-switching cache work so a context switch needs no register save/restore traffic.

Parameters:
- WIDTH, 32, data width of each register.
- DEPTH, 32, registers per bank; power of two; AW = log2(DEPTH).
- NUM_CTX, 4, number of banks; CW = max(1, log2(NUM_CTX)).
- ZERO_REG, 1, 1 = register 0 reads as zero in every bank and ignores writes.
- BYPASS, 1, 1 = same-cycle write data forwarded to a read of the same address.

Ports:
- CLK  in  1  clock; all state updates on posedge CLK.
- RESET  in  1  synchronous, active-high reset.
- WRITE  in  1  write enable for the active bank.
- INADDRESS  in  AW  write address.
- IN  in  WIDTH  write data.
- OUT1ADDRESS  in  AW  read port 1 address.
- OUT2ADDRESS  in  AW  read port 2 address.
- OUT1  out  WIDTH  read port 1 data (combinational).
- OUT2  out  WIDTH  read port 2 data (combinational).
- CTX_REQ  in  1  context-switch request (single-cycle qualifier).
- CTX_TARGET  in  CW  requested context index.
- CTX_CLEAR  in  1  zero the target bank before activating it.
- CTX_BUSY  out  1  high while a switch is in progress.
- CTX_ACK  out  1  one-cycle pulse on switch completion.
- CTX_ERR  out  1  one-cycle pulse when a request is rejected (CTX_TARGET >= NUM_CTX).
- ACTIVE_CTX  out  CW  current active bank.

Behaviour:
- Interface: one clock, CLK. RESET is synchronous and active-high, sampled on posedge CLK.
- Reset (RESET high at an edge):
  - every register in every bank <= 0; ACTIVE_CTX <= 0; FSM <= IDLE.
  - CTX_BUSY, CTX_ACK, CTX_ERR = 0 after the edge.
  - RESET overrides any in-progress CLEAR/SWITCH.
  - WRITE and CTX_REQ are ignored at a reset edge.
- Reads:
  - OUTn = bank[ACTIVE_CTX][OUTnADDRESS], combinational.
  - ZERO_REG=1 and address 0: OUTn = 0.
  - BYPASS=1 and WRITE && INADDRESS==OUTnADDRESS (and writable): OUTn = IN.
- Writes:
  - On the edge with WRITE=1: bank[ACTIVE_CTX][INADDRESS] <= IN.
  - ZERO_REG=1 and INADDRESS=0: write dropped.
- FSM states: IDLE, CLEAR, SWITCH.
  - IDLE:
    - CTX_REQ=1 and CTX_TARGET >= NUM_CTX: stay IDLE; CTX_ERR=1 for the next cycle; nothing changes.
    - CTX_REQ=1 with a valid target: latch tgt = CTX_TARGET. Go to CLEAR (cnt <= 0) if CTX_CLEAR=1, else SWITCH.
  - CLEAR: each edge bank[tgt][cnt] <= 0, cnt++. After cnt = DEPTH-1 is cleared, go to SWITCH. Lasts exactly DEPTH cycles.
  - SWITCH: at the next edge ACTIVE_CTX <= tgt, CTX_ACK=1 for the following cycle, FSM <= IDLE.
  - CTX_BUSY=1 whenever FSM != IDLE.
- Latency, request sampled at edge k:
  - no clear: ACTIVE_CTX updates and CTX_ACK asserts at edge k+1.
  - clear: ACTIVE_CTX updates and CTX_ACK asserts at edge k+1+DEPTH.
- CTX_REQ while CTX_BUSY=1: ignored and not queued. Requesters wait for CTX_ACK.
- Writes during CLEAR/SWITCH go to the old ACTIVE_CTX bank. Reads also come from the old bank until ACTIVE_CTX changes.
- tgt == ACTIVE_CTX with clear: pipeline writes are dropped for the whole CLEAR state; the clear wins. Without clear: SWITCH is a no-op apart from CTX_ACK.
- WRITE in the same cycle as the SWITCH edge lands in the old bank.
- CTX_ACK and CTX_ERR are never high together.
- CTX_BUSY deasserts in the same cycle CTX_ACK asserts.

Test Plan:
1. RESET 1 cycle, then read addresses 0..31 on both ports -> all 0; ACTIVE_CTX=0, CTX_BUSY=0.
2. Write x5=0xDEADBEEF in ctx0; switch to ctx2 (no clear) -> CTX_ACK at k+1; x5 reads 0. Write x5=0x12345678; switch back to ctx0 -> x5 reads 0xDEADBEEF.
3. Write x0=0xFFFFFFFF -> OUT1(addr 0)=0. Same-cycle WRITE x7=0xA5A5A5A5 with OUT2ADDRESS=7 -> OUT2=0xA5A5A5A5 before the edge.
4. Fill ctx1 with nonzero values, switch away, then CTX_REQ with target 1 and CTX_CLEAR=1 at edge k:
   - CTX_BUSY high for DEPTH+1 cycles; CTX_ACK at k+33.
   - all ctx1 registers read 0.
   - a second CTX_REQ issued mid-clear is ignored.
5. NUM_CTX=3, CTX_TARGET=3 -> CTX_ERR pulse of 1 cycle, ACTIVE_CTX unchanged, no CTX_ACK.
6. Assert RESET at cycle 10 of a CLEAR -> FSM IDLE, CTX_BUSY=0, all banks 0, ACTIVE_CTX=0, no CTX_ACK.
